s_ocp_slave_bridge: RTL and testbench
=====================================

Name: s_ocp_slave_bridge

Overview:
- OCP responder bridge: accepts single OCP read/write commands on an `ocp_if.slave` port and executes them on a simple memory port with variable wait states.
- Returns OCP responses: DVA on success, ERR on bad command or out-of-range address.
- Sits at the target end of the OCP link, facing `m_ocp_slave_bridge` (initiator) across `ocp_if`.
- One outstanding transaction at a time; no pipelining or bursts.

Parameters:
- DATA_WIDTH, 32, width of OCP data and memory data.
- ADDR_WIDTH, 5, width of OCP address and memory address.
- MEM_DEPTH, 32, number of valid words; any address >= MEM_DEPTH gets ERR without a memory access.
- TIMEOUT_CYCLES, 16, memory wait limit; used only with OCP_SLV_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, all registers hold (state, outputs, counter).
- s_ocp  ocp_if.slave  -  reads m_cmd[2:0], m_addr, m_data, m_resp_accept; drives s_cmd_accept, s_resp[1:0], s_data.
- mem_req  out  1  memory access request, held until mem_ready.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_WIDTH  registered command address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_rdata  in  DATA_WIDTH  read data; valid when mem_ready is high.
- mem_ready  in  1  access complete this cycle.
- busy  out  1  high in every state except IDLE.
- err_count  out  8  saturating count of ERR responses issued.

Behaviour:
- Encodings:
  - Commands: 000 IDLE, 001 WR, 010 RD; any other nonzero code is illegal.
  - Responses: 00 NULL, 01 DVA, 10 FAIL (never driven), 11 ERR.
- Reset (asynchronous) values: state = IDLE; s_cmd_accept, s_resp, s_data, mem_req, mem_we, mem_addr, mem_wdata, err_count all 0.
- Reset asserted mid-transaction abandons the transaction; mem_req drops immediately.
- State machine states: IDLE, ACCEPT, MEM, RESP.
- IDLE:
  - If m_cmd != 000, register cmd, m_addr and m_data.
  - Drive s_cmd_accept = 1 on the next cycle and go to ACCEPT.
- ACCEPT (1 cycle):
  - s_cmd_accept returns to 0.
  - Legal command with address < MEM_DEPTH: assert mem_req with mem_we = (cmd == WR); go to MEM.
  - Illegal command or address >= MEM_DEPTH: load s_resp = ERR, s_data = 0; go to RESP.
  - m_cmd is ignored here; the initiator drops it on the edge where it samples s_cmd_accept.
- MEM:
  - Hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ready = 1.
  - On mem_ready: drop mem_req; load s_resp = DVA; for a read, s_data = mem_rdata; for a write, s_data holds its previous value. Go to RESP.
  - mem_ready while mem_req is low is ignored.
- RESP:
  - Hold s_resp and s_data until m_resp_accept = 1 is sampled.
  - On that edge: s_resp = NULL, increment err_count if the response was ERR (saturates at 255), go to IDLE.
- Command-to-response latency, zero wait states: s_resp valid 3 cycles after m_cmd is sampled. Each memory wait cycle adds 1.
- Back-to-back: a new command can be sampled in the cycle after returning to IDLE.
- m_resp_accept already high on entry to RESP: completes in one cycle.
- enable low in any state freezes everything. mem_ready arriving while enable is low is not captured; the memory must hold mem_ready until enable returns.

Optional Feature:
- Macro: OCP_SLV_TIMEOUT_EN.
- Defined:
  - A 0..TIMEOUT_CYCLES counter runs in MEM.
  - If mem_ready is still low after TIMEOUT_CYCLES cycles in MEM, drop mem_req, load s_resp = ERR, s_data = 0, go to RESP.
  - mem_ready in the same cycle as expiry wins and gives DVA.
- Not defined: MEM waits indefinitely; no counter logic is present.

Decomposition:
- Add to ocp_pkg: command encodings (OCP_CMD_IDLE/WR/RD), response encodings (OCP_RESP_NULL/DVA/FAIL/ERR), and the slave state enum `ocp_slv_state_t`.
- No sub-module; the timeout counter and err_count live inline.

Test Plan:
- WR 001, addr 5, data 0xDEADBEEF, mem_ready 1 cycle after mem_req -> mem_we = 1, mem_addr = 5, mem_wdata = 0xDEADBEEF; s_resp = 01; master completes; err_count = 0.
- RD addr 7, mem_rdata 0x12345678 with 3 wait states -> mem_req high 4 cycles; s_resp = 01, s_data = 0x12345678; latency 6 cycles.
- Cmd 011 (illegal), and RD addr 31 with MEM_DEPTH = 20 -> no mem_req; s_resp = 11 both times; err_count = 2.
- Reset asserted in MEM with mem_req high -> all outputs 0 immediately; a following WR completes normally.
- enable low for 4 cycles during RESP and during ACCEPT -> outputs and state frozen; transaction resumes correctly when enable returns.
- OCP_SLV_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_ready never asserted -> after 4 MEM cycles s_resp = 11, mem_req = 0; 260 errors -> err_count = 255.

Source files
------------

// File: rtl/s_ocp_slave_bridge_pkg.sv
// Shared OCP definitions: command/response encodings and the responder state enum.
package ocp_pkg;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WR    = 3'b001;
  localparam logic [2:0] OCP_CMD_RD    = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    SLV_IDLE   = 2'd0,
    SLV_ACCEPT = 2'd1,
    SLV_MEM    = 2'd2,
    SLV_RESP   = 2'd3
  } ocp_slv_state_t;

  // Only plain single-word writes and reads are executable commands.
  function automatic logic ocp_cmd_legal(input logic [2:0] cmd);
    return (cmd == OCP_CMD_WR) || (cmd == OCP_CMD_RD);
  endfunction

endpackage

// File: rtl/s_ocp_slave_bridge_if.sv
// OCP link between an initiator (master) and a responder (slave).
interface ocp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [2:0]            m_cmd;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_resp_accept;
  logic                  s_cmd_accept;
  logic [1:0]            s_resp;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (
    output m_cmd, m_addr, m_data, m_resp_accept,
    input  s_cmd_accept, s_resp, s_data
  );

  modport slave (
    input  m_cmd, m_addr, m_data, m_resp_accept,
    output s_cmd_accept, s_resp, s_data
  );
endinterface

// File: rtl/s_ocp_slave_bridge.sv
// OCP responder bridge: one OCP read/write at a time executed on a simple
// memory port with variable wait states. DVA on success, ERR on an illegal
// command or an address >= MEM_DEPTH. Optional memory wait limit is enabled
// by defining OCP_SLV_TIMEOUT_EN.
module s_ocp_slave_bridge
  import ocp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int MEM_DEPTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  ocp_if.slave                  s_ocp,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic [7:0]            err_count
);

  ocp_slv_state_t        r_state, w_state_nxt;
  logic [2:0]            r_cmd, w_cmd_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_cmd_accept, w_cmd_accept_nxt;
  logic [1:0]            r_resp, w_resp_nxt;
  logic [DATA_WIDTH-1:0] r_sdata, w_sdata_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [7:0]            r_err_count, w_err_count_nxt;
  logic                  w_cmd_ok;
  logic                  w_tmo;

  // A command is executed only if it is legal and addresses an existing word.
  assign w_cmd_ok = ocp_cmd_legal(r_cmd) && (32'(r_addr) < 32'(MEM_DEPTH));

`ifdef OCP_SLV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Expiry when this MEM cycle would be the TIMEOUT_CYCLES-th one without ready.
  assign w_tmo = ((r_tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES));

  // Count cycles spent in MEM; cleared when the access is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (enable) begin
      if (r_state == SLV_ACCEPT) begin
        r_tmo_cnt <= '0;
      end else if (r_state == SLV_MEM) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end
`else
  // Without the wait limit the memory may stall indefinitely.
  assign w_tmo = 1'b0;
`endif

  // State register; enable low freezes the machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SLV_IDLE;
    end else if (enable) begin
      r_state <= w_state_nxt;
    end else begin
      r_state <= r_state;
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLV_IDLE: begin
        if (s_ocp.m_cmd != OCP_CMD_IDLE) w_state_nxt = SLV_ACCEPT;
        else                             w_state_nxt = SLV_IDLE;
      end
      SLV_ACCEPT: begin
        if (w_cmd_ok) w_state_nxt = SLV_MEM;
        else          w_state_nxt = SLV_RESP;
      end
      SLV_MEM: begin
        if (mem_ready || w_tmo) w_state_nxt = SLV_RESP;
        else                    w_state_nxt = SLV_MEM;
      end
      SLV_RESP: begin
        if (s_ocp.m_resp_accept) w_state_nxt = SLV_IDLE;
        else                     w_state_nxt = SLV_RESP;
      end
      default: w_state_nxt = SLV_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    w_cmd_nxt        = r_cmd;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_cmd_accept_nxt = r_cmd_accept;
    w_resp_nxt       = r_resp;
    w_sdata_nxt      = r_sdata;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_err_count_nxt  = r_err_count;
    case (r_state)
      SLV_IDLE: begin
        if (s_ocp.m_cmd != OCP_CMD_IDLE) begin
          w_cmd_nxt        = s_ocp.m_cmd;
          w_addr_nxt       = s_ocp.m_addr;
          w_wdata_nxt      = s_ocp.m_data;
          w_cmd_accept_nxt = 1'b1;
        end else begin
          w_cmd_accept_nxt = 1'b0;
        end
      end
      SLV_ACCEPT: begin
        w_cmd_accept_nxt = 1'b0;
        if (w_cmd_ok) begin
          w_mem_req_nxt = 1'b1;
          w_mem_we_nxt  = (r_cmd == OCP_CMD_WR);
        end else begin
          w_resp_nxt  = OCP_RESP_ERR;
          w_sdata_nxt = '0;
        end
      end
      SLV_MEM: begin
        // A ready in the expiry cycle still completes the access normally.
        if (mem_ready) begin
          w_mem_req_nxt = 1'b0;
          w_resp_nxt    = OCP_RESP_DVA;
          if (!r_mem_we) w_sdata_nxt = mem_rdata;
          else           w_sdata_nxt = r_sdata;
        end else if (w_tmo) begin
          w_mem_req_nxt = 1'b0;
          w_resp_nxt    = OCP_RESP_ERR;
          w_sdata_nxt   = '0;
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      SLV_RESP: begin
        if (s_ocp.m_resp_accept) begin
          w_resp_nxt = OCP_RESP_NULL;
          if ((r_resp == OCP_RESP_ERR) && (r_err_count != 8'hFF)) begin
            w_err_count_nxt = r_err_count + 8'd1;
          end else begin
            w_err_count_nxt = r_err_count;
          end
        end else begin
          w_resp_nxt = r_resp;
        end
      end
      default: begin
        w_cmd_accept_nxt = 1'b0;
        w_mem_req_nxt    = 1'b0;
        w_resp_nxt       = OCP_RESP_NULL;
      end
    endcase
  end

  // Output and command registers; enable low freezes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd        <= OCP_CMD_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cmd_accept <= 1'b0;
      r_resp       <= OCP_RESP_NULL;
      r_sdata      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_err_count  <= 8'd0;
    end else if (enable) begin
      r_cmd        <= w_cmd_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_cmd_accept <= w_cmd_accept_nxt;
      r_resp       <= w_resp_nxt;
      r_sdata      <= w_sdata_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_err_count  <= w_err_count_nxt;
    end else begin
      r_cmd        <= r_cmd;
      r_addr       <= r_addr;
      r_wdata      <= r_wdata;
      r_cmd_accept <= r_cmd_accept;
      r_resp       <= r_resp;
      r_sdata      <= r_sdata;
      r_mem_req    <= r_mem_req;
      r_mem_we     <= r_mem_we;
      r_err_count  <= r_err_count;
    end
  end

  assign s_ocp.s_cmd_accept = r_cmd_accept;
  assign s_ocp.s_resp       = r_resp;
  assign s_ocp.s_data       = r_sdata;
  assign mem_req            = r_mem_req;
  assign mem_we             = r_mem_we;
  assign mem_addr           = r_addr;
  assign mem_wdata          = r_wdata;
  assign err_count          = r_err_count;
  assign busy               = (r_state != SLV_IDLE);

endmodule

// File: tb/tb_s_ocp_slave_bridge.sv
// Directed self-checking bench for s_ocp_slave_bridge (MEM_DEPTH = 20,
// TIMEOUT_CYCLES = 4). Timeout cases run only when OCP_SLV_TIMEOUT_EN is defined.
module tb_s_ocp_slave_bridge;
  import ocp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_req;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  // Per-transaction observations.
  logic [1:0]  t_resp;
  logic [31:0] t_data;
  int          t_lat;
  int          t_req;
  logic        t_we;
  logic [4:0]  t_addr;
  logic [31:0] t_wdata;

  ocp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ocp ();

  s_ocp_slave_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_DEPTH(20), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_ocp(ocp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drop enable for 4 cycles; the visible state must not move.
  task automatic freeze4(input string tag, input logic exp_acc, input logic [1:0] exp_resp);
    enable = 1'b0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_acc"},  32'(ocp.s_cmd_accept), 32'(exp_acc));
      check({tag, "_resp"}, 32'(ocp.s_resp),       32'(exp_resp));
      check({tag, "_busy"}, 32'(busy),             32'd1);
      check({tag, "_req"},  32'(mem_req),          32'd0);
    end
    enable = 1'b1;
  endtask

  // One complete OCP transaction with a simple memory model.
  // waits < 0 means the memory never answers; freeze 1 = in ACCEPT, 2 = in RESP.
  task automatic run_txn(input logic [2:0] cmd, input logic [4:0] addr,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] rdata, input int freeze,
                         input logic early_acc);
    int  n;
    bit  done;
    @(negedge clk);
    ocp.m_cmd = cmd; ocp.m_addr = addr; ocp.m_data = wdata;
    ocp.m_resp_accept = early_acc;
    n = 0; done = 1'b0; t_lat = -1; t_req = 0;
    t_resp = 2'b00; t_data = 32'd0; t_we = 1'b0; t_addr = 5'd0; t_wdata = 32'd0;
    while (!done && n < 200) begin
      @(posedge clk); @(negedge clk);
      n++;
      mem_ready = 1'b0;
      if (t_lat >= 0) begin
        done = 1'b1;
        ocp.m_resp_accept = 1'b0;
      end else begin
        if (ocp.s_cmd_accept) begin
          ocp.m_cmd = OCP_CMD_IDLE;
          if (freeze == 1) begin
            freeze4("frz_acc", 1'b1, OCP_RESP_NULL);
            n += 4;
          end
        end
        if (mem_req) begin
          t_req++;
          t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata;
          if (t_req == waits + 1) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
          end
        end
        if (ocp.s_resp != OCP_RESP_NULL) begin
          t_lat = n; t_resp = ocp.s_resp; t_data = ocp.s_data;
          if (freeze == 2) freeze4("frz_resp", 1'b0, OCP_RESP_DVA);
          ocp.m_resp_accept = 1'b1;
        end
      end
    end
    check("txn_done", 32'(done), 32'd1);
    check("idle_resp", 32'(ocp.s_resp), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    ocp.m_cmd = OCP_CMD_IDLE;
    ocp.m_resp_accept = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    ocp.m_cmd = OCP_CMD_IDLE; ocp.m_addr = 5'd0; ocp.m_data = 32'd0;
    ocp.m_resp_accept = 1'b0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_acc",   32'(ocp.s_cmd_accept), 32'd0);
    check("rst_resp",  32'(ocp.s_resp),       32'd0);
    check("rst_sdata", ocp.s_data,            32'd0);
    check("rst_req",   32'(mem_req),          32'd0);
    check("rst_we",    32'(mem_we),           32'd0);
    check("rst_addr",  32'(mem_addr),         32'd0);
    check("rst_wdata", mem_wdata,             32'd0);
    check("rst_err",   32'(err_count),        32'd0);
    check("rst_busy",  32'(busy),             32'd0);

    // Write, zero wait states.
    run_txn(OCP_CMD_WR, 5'd5, 32'hDEADBEEF, 0, 32'h0, 0, 1'b0);
    check("wr_we",    32'(t_we),    32'd1);
    check("wr_addr",  32'(t_addr),  32'd5);
    check("wr_wdata", t_wdata,      32'hDEADBEEF);
    check("wr_req",   32'(t_req),   32'd1);
    check("wr_resp",  32'(t_resp),  32'(OCP_RESP_DVA));
    check("wr_sdata", t_data,       32'd0);
    check("wr_lat",   32'(t_lat),   32'd3);
    check("wr_err",   32'(err_count), 32'd0);

    // Read, three wait states.
    run_txn(OCP_CMD_RD, 5'd7, 32'h0, 3, 32'h12345678, 0, 1'b0);
    check("rd_we",    32'(t_we),   32'd0);
    check("rd_addr",  32'(t_addr), 32'd7);
    check("rd_req",   32'(t_req),  32'd4);
    check("rd_resp",  32'(t_resp), 32'(OCP_RESP_DVA));
    check("rd_sdata", t_data,      32'h12345678);
    check("rd_lat",   32'(t_lat),  32'd6);

    // Illegal command: ERR, no memory access.
    run_txn(3'b011, 5'd2, 32'h0, 0, 32'h0, 0, 1'b0);
    check("ill_req",   32'(t_req),  32'd0);
    check("ill_resp",  32'(t_resp), 32'(OCP_RESP_ERR));
    check("ill_sdata", t_data,      32'd0);
    check("ill_lat",   32'(t_lat),  32'd2);

    // Out-of-range read.
    run_txn(OCP_CMD_RD, 5'd31, 32'h0, 0, 32'hFFFFFFFF, 0, 1'b0);
    check("oor_req",  32'(t_req),  32'd0);
    check("oor_resp", 32'(t_resp), 32'(OCP_RESP_ERR));
    check("oor_err",  32'(err_count), 32'd2);
    exp_err = 2;

    // Last valid address, response already accepted on entry to RESP.
    run_txn(OCP_CMD_RD, 5'd19, 32'h0, 0, 32'h0BADCAFE, 0, 1'b1);
    check("edge_req",   32'(t_req),  32'd1);
    check("edge_resp",  32'(t_resp), 32'(OCP_RESP_DVA));
    check("edge_sdata", t_data,      32'h0BADCAFE);

    // Freeze in ACCEPT: latency stretches by 4.
    run_txn(OCP_CMD_RD, 5'd4, 32'h0, 0, 32'hAAAA5555, 1, 1'b0);
    check("fa_resp",  32'(t_resp), 32'(OCP_RESP_DVA));
    check("fa_sdata", t_data,      32'hAAAA5555);
    check("fa_lat",   32'(t_lat),  32'd7);

    // Freeze in RESP after a write: s_data keeps the earlier read data.
    run_txn(OCP_CMD_WR, 5'd1, 32'h01020304, 0, 32'h0, 2, 1'b0);
    check("fr_resp",  32'(t_resp), 32'(OCP_RESP_DVA));
    check("fr_sdata", t_data,      32'hAAAA5555);
    check("fr_lat",   32'(t_lat),  32'd3);
    check("fr_err",   32'(err_count), 32'(exp_err));

    // Reset while the memory access is pending.
    @(negedge clk);
    ocp.m_cmd = OCP_CMD_WR; ocp.m_addr = 5'd9; ocp.m_data = 32'hCAFEF00D;
    @(negedge clk);
    check("mr_acc", 32'(ocp.s_cmd_accept), 32'd1);
    ocp.m_cmd = OCP_CMD_IDLE;
    @(negedge clk);
    check("mr_req_pre", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_req",   32'(mem_req),      32'd0);
    check("mr_we",    32'(mem_we),       32'd0);
    check("mr_addr",  32'(mem_addr),     32'd0);
    check("mr_wdata", mem_wdata,         32'd0);
    check("mr_sdata", ocp.s_data,        32'd0);
    check("mr_err",   32'(err_count),    32'd0);
    check("mr_busy",  32'(busy),         32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
    run_txn(OCP_CMD_WR, 5'd9, 32'hCAFEF00D, 1, 32'h0, 0, 1'b0);
    check("mr2_addr",  32'(t_addr), 32'd9);
    check("mr2_wdata", t_wdata,     32'hCAFEF00D);
    check("mr2_resp",  32'(t_resp), 32'(OCP_RESP_DVA));
    check("mr2_lat",   32'(t_lat),  32'd4);

`ifdef OCP_SLV_TIMEOUT_EN
    // Memory never answers: ERR after 4 MEM cycles.
    run_txn(OCP_CMD_WR, 5'd2, 32'h55AA55AA, -1, 32'h0, 0, 1'b0);
    check("to_req",   32'(t_req),   32'd4);
    check("to_resp",  32'(t_resp),  32'(OCP_RESP_ERR));
    check("to_sdata", t_data,       32'd0);
    check("to_lat",   32'(t_lat),   32'd6);
    check("to_mreq",  32'(mem_req), 32'd0);
    exp_err = 1;
    // Ready in the expiry cycle wins.
    run_txn(OCP_CMD_RD, 5'd3, 32'h0, 3, 32'h600DF00D, 0, 1'b0);
    check("tw_resp",  32'(t_resp), 32'(OCP_RESP_DVA));
    check("tw_sdata", t_data,      32'h600DF00D);
`endif

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      if (i % 3 == 0)      run_txn(3'b011, 5'd0, 32'h0, 0, 32'h0, 0, 1'b1);
      else if (i % 3 == 1) run_txn(3'b111, 5'd0, 32'h0, 0, 32'h0, 0, 1'b1);
      else                 run_txn(OCP_CMD_RD, 5'd20, 32'h0, 0, 32'h0, 0, 1'b1);
      check("sat_resp", 32'(t_resp), 32'(OCP_RESP_ERR));
      check("sat_req",  32'(t_req),  32'd0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
    check("sat_err", 32'(err_count), 32'd255);
    check("sat_model", 32'(exp_err), 32'(err_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
